// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: quadrant pre-rotation, then ITER micro-rotations at one per clock.
// Results keep the ~1.6468 CORDIC gain; one operation in flight, sequenced by start/done.
module cordic_rotator #(
  parameter int ITER = 16,
  parameter int DW   = 19,
  parameter int ZW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   x_in,
  input  logic [15:0]   y_in,
  input  logic [ZW-1:0] z_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [ZW-1:0] z_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, FIN = 2'd2} state_t;

  localparam logic [4:0]           LAST = 5'(ITER - 1);
  localparam logic signed [ZW-1:0] QTR  = {2'b01, {(ZW-2){1'b0}}};

  state_t               state_q, state_d;
  logic [4:0]           i_q, i_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, xs, ys;
  logic signed [DW-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic signed [ZW-1:0] z_q, z_d, z_out_q, z_out_d;
  logic                 done_q, done_d;

  // atan(2^-i) with pi == 2^(ZW-1)
  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] idx);
    logic [15:0] v;
    case (idx)
      5'd0:  v = 16'd8192;
      5'd1:  v = 16'd4836;
      5'd2:  v = 16'd2555;
      5'd3:  v = 16'd1297;
      5'd4:  v = 16'd651;
      5'd5:  v = 16'd326;
      5'd6:  v = 16'd163;
      5'd7:  v = 16'd81;
      5'd8:  v = 16'd41;
      5'd9:  v = 16'd20;
      5'd10: v = 16'd10;
      5'd11: v = 16'd5;
      5'd12: v = 16'd3;
      5'd13: v = 16'd1;
      5'd14: v = 16'd1;
      default: v = 16'd0;
    endcase
    return ZW'(v);
  endfunction

  assign xs = {{(DW-16){x_in[15]}}, x_in};
  assign ys = {{(DW-16){y_in[15]}}, y_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ROT;
      ROT:     if (i_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        i_d = '0;
        // fold angles beyond +-pi/2 into the convergence range with an exact 90-degree turn
        case (z_in[ZW-1 -: 2])
          2'b01: begin x_d = -ys; y_d = xs;  z_d = z_in - QTR; end
          2'b10: begin x_d = ys;  y_d = -xs; z_d = z_in + QTR; end
          default: begin x_d = xs; y_d = ys; z_d = z_in; end
        endcase
      end
      ROT: begin
        i_d = i_q + 5'd1;
        if (!z_q[ZW-1]) begin
          x_d = x_q - (y_q >>> i_q);
          y_d = y_q + (x_q >>> i_q);
          z_d = z_q - atan_lut(i_q);
        end else begin
          x_d = x_q + (y_q >>> i_q);
          y_d = y_q - (x_q >>> i_q);
          z_d = z_q + atan_lut(i_q);
        end
      end
      FIN: begin
        x_out_d = x_q;
        y_out_d = y_q;
        z_out_d = z_q;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
      done_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
      done_q <= done_d;
    end
  end

  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;
endmodule

// File: tb/tb_cordic_rotator.sv
// Randomized and directed checks of cordic_rotator against a floating-point rotation model.
module tb_cordic_rotator;
  localparam int ITER = 16;
  localparam int DW   = 19;
  localparam int ZW   = 16;
  localparam int TOL  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   x_in, y_in;
  logic [ZW-1:0] z_in;
  logic          busy, done;
  logic [DW-1:0] x_out, y_out;
  logic [ZW-1:0] z_out;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_rotator #(.ITER(ITER), .DW(DW), .ZW(ZW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_tests++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, obs, exp, tol);
    end
  endtask

  // ideal rotation by z*pi/2^(ZW-1), scaled by the CORDIC gain
  function automatic void model(input int xi, input int yi, input int zi,
                                output longint ex, output longint ey);
    real a;
    a  = real'(zi) * 3.14159265358979 / 32768.0;
    ex = longint'(1.6468 * (real'(xi) * $cos(a) - real'(yi) * $sin(a)));
    ey = longint'(1.6468 * (real'(xi) * $sin(a) + real'(yi) * $cos(a)));
  endfunction

  task automatic run_op(input logic [15:0] xi, input logic [15:0] yi, input logic [ZW-1:0] zi,
                        output longint lat, output longint xo, output longint yo, output longint zo);
    int k;
    bit busy_bad;
    busy_bad = 1'b0;
    @(negedge clk);
    x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x_in = 16'h1234; y_in = 16'h4321; z_in = 16'h2000;
    k = 0;
    while (k < 100 && done !== 1'b1) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    if (busy !== 1'b0) busy_bad = 1'b1;
    check("busy_window", longint'(busy_bad), 0, 0);
    lat = k;
    xo = longint'($signed(x_out));
    yo = longint'($signed(y_out));
    zo = longint'($signed(z_out));
  endtask

  initial begin
    longint lat, xo, yo, zo, ex, ey;
    int ndone, mism, xr, yr, zr;
    int dq[$];

    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_x", longint'(x_out), 0, 0);
    check("rst_y", longint'(y_out), 0, 0);
    check("rst_z", longint'(z_out), 0, 0);
    rst = 1'b0;

    run_op(16'd16384, 16'd0, 16'd0, lat, xo, yo, zo);
    check("zero_latency", lat, ITER + 1, 0);
    check("zero_x", xo, 26981, TOL);
    check("zero_y", yo, 0, TOL);

    run_op(16'd16384, 16'd0, 16'd8192, lat, xo, yo, zo);
    check("pi4_x", xo, 19079, TOL);
    check("pi4_y", yo, 19079, TOL);
    check("pi4_z", zo, 0, 2);

    run_op(16'd16384, 16'd0, 16'd16384, lat, xo, yo, zo);
    check("pi2_x", xo, 0, TOL);
    check("pi2_y", yo, 26981, TOL);

    run_op(16'd16384, 16'd0, 16'h8000, lat, xo, yo, zo);
    check("mpi_x", xo, -26981, TOL);
    check("mpi_y", yo, 0, TOL);

    // start pulse mid-operation must be ignored
    @(negedge clk);
    x_in = 16'd16384; y_in = '0; z_in = '0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; xo = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin ndone++; xo = longint'($signed(x_out)); end
      if (c == 5) begin start = 1'b1; x_in = 16'd1000; z_in = 16'd8192; end
      if (c == 6) start = 1'b0;
    end
    check("ignore_ndone", ndone, 1, 0);
    check("ignore_x", xo, 26981, TOL);

    // start held high: back-to-back operations
    @(negedge clk);
    x_in = 16'd16384; y_in = '0; z_in = '0; start = 1'b1;
    @(posedge clk);
    mism = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) dq.push_back(c);
      if (busy == done) mism++;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_ndone", dq.size(), 2, 0);
    if (dq.size() == 2) check("hold_period", dq[1] - dq[0], ITER + 2, 0);
    check("hold_busy_vs_done", mism, 0, 0);
    ndone = 0;
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    check("hold_drain", ndone, 1, 0);

    // reset in the middle of an operation
    @(negedge clk);
    x_in = 16'd16384; y_in = '0; z_in = 16'd8192; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0, 0);
    check("midrst_x", longint'(x_out), 0, 0);
    check("midrst_y", longint'(y_out), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_nodone", ndone, 0, 0);
    run_op(16'd16384, 16'd0, 16'd0, lat, xo, yo, zo);
    check("postrst_lat", lat, ITER + 1, 0);
    check("postrst_x", xo, 26981, TOL);

    // random sweep
    for (int n = 0; n < 24; n++) begin
      xr = int'($urandom_range(46338)) - 23169;
      yr = int'($urandom_range(46338)) - 23169;
      zr = int'($urandom_range(65535)) - 32768;
      model(xr, yr, zr, ex, ey);
      run_op(16'(xr), 16'(yr), ZW'(zr), lat, xo, yo, zo);
      check("sweep_lat", lat, ITER + 1, 0);
      check("sweep_x", xo, ex, TOL);
      check("sweep_y", yo, ey, TOL);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
